// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - VRAM arbiter: display-priority fetch port plus single-slot CPU access port.
// Optional macro VRAM_ARB_STARVE_EN forces a CPU grant after MAXWAIT deferred cycles.
module vram_arb #(
  parameter int AW      = 14,
  parameter int MAXWAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [7:0]    disp_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_rvalid,
  output logic [7:0]    cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cpu_state_t;

  typedef struct packed {
    logic rd;
    logic cpu;
  } tag_t;

  cpu_state_t    state;
  cpu_state_t    state_nxt;
  logic          capture;
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [7:0]    hold_wdata;
  logic          cpu_gnt;
  logic          cpu_force;
  tag_t          tag1;
  tag_t          tag2;

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAXWAIT);
  logic [7:0] wait_cnt;

  // Counts deferred PEND cycles; saturation at WAIT_MAX is what triggers the forced grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state == PEND && !cpu_gnt) begin
      if (wait_cnt < WAIT_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  assign cpu_force = (state == PEND) && (wait_cnt == WAIT_MAX);
`else
  assign cpu_force = 1'b0;
`endif

  always_comb begin
    cpu_gnt  = (state == PEND) && (!disp_req || cpu_force);
    disp_gnt = disp_req && !cpu_force;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          capture   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cpu_gnt) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= 8'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_we    <= cpu_we;
        hold_addr  <= cpu_addr;
        hold_wdata <= cpu_wdata;
      end
    end
  end

  assign cpu_busy = (state == PEND);

  // Issue stage: the tag rides alongside the address so read data can be routed three cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
      tag1      <= '0;
    end else if (cpu_gnt) begin
      mem_addr  <= hold_addr;
      mem_we    <= hold_we;
      mem_wdata <= hold_wdata;
      tag1      <= '{rd: !hold_we, cpu: 1'b1};
    end else if (disp_gnt) begin
      mem_addr  <= disp_addr;
      mem_we    <= 1'b0;
      tag1      <= '{rd: 1'b1, cpu: 1'b0};
    end else begin
      mem_we    <= 1'b0;
      tag1      <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag2        <= '0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rdata  <= 8'd0;
      cpu_rdata   <= 8'd0;
    end else begin
      tag2        <= tag1;
      disp_rvalid <= tag2.rd && !tag2.cpu;
      cpu_rvalid  <= tag2.rd && tag2.cpu;
      if (tag2.rd && !tag2.cpu) begin
        disp_rdata <= mem_rdata;
      end
      if (tag2.rd && tag2.cpu) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - directed self-checking bench for vram_arb with a behavioural VRAM model.
module tb_vram_arb;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [7:0]    disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_busy;
  logic          cpu_rvalid;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  vram_arb #(.AW(AW), .MAXWAIT(8)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // VRAM: data for the address presented in one cycle appears in the next.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7) + 3);
  endfunction

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req  = 1'b0;
    disp_addr = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc_begin();
    cyc_begin();
    @(negedge clk);
    checks++; if (mem_addr !== 14'd0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_cpu_busy got=%b exp=0", cpu_busy); end
    checks++; if ({disp_rvalid, cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", {disp_rvalid, cpu_rvalid}); end
    checks++; if ({disp_rdata, cpu_rdata} !== 16'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {disp_rdata, cpu_rdata}); end
    cyc_begin();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc_begin();
  endtask

  task automatic test_cpu_read();
    mem[14'h0123] = 8'h5A;
    cyc_begin();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    @(negedge clk);
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_c0 got=%b exp=0", cpu_busy); end
    cyc_begin();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c1 got=%b exp=1", cpu_busy); end
    checks++; if (disp_gnt !== 1'b0) begin errors++; $display("FAIL rd_disp_gnt got=%b exp=0", disp_gnt); end
    cyc_begin();
    @(negedge clk);
    checks++; if (mem_addr !== 14'h0123 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_issue addr=%h we=%b exp addr=0123 we=0", mem_addr, mem_we); end
    checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_c2 got=%b exp=0", cpu_busy); end
    cyc_begin();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early got=%b exp=0", cpu_rvalid); end
    cyc_begin();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data rvalid=%b data=%h exp 1/5a", cpu_rvalid, cpu_rdata); end
    cyc_begin();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got=%b exp=0", cpu_rvalid); end
    for (int i = 0; i < 3; i++) cyc_begin();
  endtask

  task automatic test_disp_stream();
    for (int i = 0; i < 24; i++) begin
      cyc_begin();
      disp_req  = (i < 20);
      disp_addr = 14'(i);
      @(negedge clk);
      if (i < 20) begin
        checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL disp_gnt i=%0d got=%b exp=1", i, disp_gnt); end
      end
      if (i >= 3 && i < 23) begin
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== init_val(i - 3)) begin
          errors++; $display("FAIL disp_data i=%0d rvalid=%b data=%h exp 1/%h", i, disp_rvalid, disp_rdata, init_val(i - 3));
        end
      end else begin
        checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL disp_rvalid_idle i=%0d got=%b exp=0", i, disp_rvalid); end
      end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL disp_cpu_rvalid i=%0d got=%b exp=0", i, cpu_rvalid); end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) cyc_begin();
  endtask

  task automatic test_starve();
    int g;
`ifdef VRAM_ARB_STARVE_EN
    g = 9;
`else
    g = 16;
`endif
    for (int j = 0; j <= 20; j++) begin
      cyc_begin();
      disp_req  = (j < 16);
      disp_addr = 14'(100 + j);
      cpu_req   = (j == 0);
      cpu_we    = 1'b1;
      cpu_addr  = 14'h3FFF;
      cpu_wdata = 8'hA5;
      @(negedge clk);
      checks++;
      if (disp_gnt !== ((j < 16) && (j != g))) begin
        errors++; $display("FAIL starve_disp_gnt j=%0d got=%b exp=%b", j, disp_gnt, ((j < 16) && (j != g)));
      end
      checks++;
      if (mem_we !== (j == g + 1)) begin
        errors++; $display("FAIL starve_mem_we j=%0d got=%b exp=%b", j, mem_we, (j == g + 1));
      end
      checks++;
      if (cpu_busy !== ((j >= 1) && (j <= g))) begin
        errors++; $display("FAIL starve_busy j=%0d got=%b exp=%b", j, cpu_busy, ((j >= 1) && (j <= g)));
      end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL starve_cpu_rvalid j=%0d got=%b exp=0", j, cpu_rvalid); end
      if (j == g + 1) begin
        checks++;
        if (mem_addr !== 14'h3FFF || mem_wdata !== 8'hA5) begin
          errors++; $display("FAIL starve_issue addr=%h wdata=%h exp 3fff/a5", mem_addr, mem_wdata);
        end
      end
    end
    idle_inputs();
    cyc_begin();
    checks++; if (mem[14'h3FFF] !== 8'hA5) begin errors++; $display("FAIL starve_mem_content got=%h exp=a5", mem[14'h3FFF]); end
    for (int i = 0; i < 3; i++) cyc_begin();
  endtask

  task automatic test_busy_ignore();
    cyc_begin();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
    cyc_begin();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0020; cpu_wdata = 8'hEE;
    @(negedge clk);
    checks++; if (cpu_busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", cpu_busy); end
    cyc_begin();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 14'h0010 || mem_we !== 1'b0) begin errors++; $display("FAIL ign_issue addr=%h we=%b exp 0010/0", mem_addr, mem_we); end
    for (int k = 3; k <= 6; k++) begin
      cyc_begin();
      @(negedge clk);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 14'h0010) begin errors++; $display("FAIL ign_hold k=%0d addr=%h we=%b exp 0010/0", k, mem_addr, mem_we); end
      checks++; if (cpu_busy !== 1'b0) begin errors++; $display("FAIL ign_busy_low k=%0d got=%b exp=0", k, cpu_busy); end
      checks++;
      if (cpu_rvalid !== (k == 4) || (k == 4 && cpu_rdata !== init_val(16))) begin
        errors++; $display("FAIL ign_rvalid k=%0d rvalid=%b data=%h exp %b/%h", k, cpu_rvalid, cpu_rdata, (k == 4), init_val(16));
      end
    end
    checks++; if (mem[14'h0020] !== init_val(32)) begin errors++; $display("FAIL ign_mem_content got=%h exp=%h", mem[14'h0020], init_val(32)); end
  endtask

  task automatic test_reset_midop();
    cyc_begin();
    disp_req = 1'b1; disp_addr = 14'd5;
    @(negedge clk);
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("FAIL rst_disp_gnt got=%b exp=1", disp_gnt); end
    cyc_begin();
    disp_req = 1'b0; reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'd7; cpu_wdata = 8'h11;
    cyc_begin();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_addr !== 14'd0 || mem_we !== 1'b0 || mem_wdata !== 8'd0) begin
      errors++; $display("FAIL rst_mem addr=%h we=%b wdata=%h exp 0/0/0", mem_addr, mem_we, mem_wdata);
    end
    checks++;
    if (disp_rdata !== 8'd0 || cpu_rdata !== 8'd0) begin
      errors++; $display("FAIL rst_rdata disp=%h cpu=%h exp 0/0", disp_rdata, cpu_rdata);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        cyc_begin();
        @(negedge clk);
      end
      checks++;
      if (disp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_busy !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL rst_quiet k=%0d drv=%b crv=%b busy=%b we=%b exp all 0", k, disp_rvalid, cpu_rvalid, cpu_busy, mem_we);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(a);
    mem_rdata = 8'd0;
    test_reset();
    test_cpu_read();
    test_disp_stream();
    test_starve();
    test_busy_ignore();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter AW, 14, VRAM address width in bits.
REQ-002 Parameter MAXWAIT, 8, cycles a pending CPU access may be deferred before it is forced (range 1..255).
REQ-003 clk  in  1  pixel clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 disp_req  in  1  display fetch request, level, sampled every cycle.
REQ-006 disp_addr  in  AW  display fetch address.
REQ-007 disp_gnt  out  1  combinational; display request accepted this cycle.
REQ-008 disp_rvalid  out  1  one-cycle pulse, disp_rdata valid.
REQ-009 disp_rdata  out  8  display read data.
REQ-010 cpu_req  in  1  single-cycle CPU access strobe.
REQ-011 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-012 cpu_addr  in  AW  CPU access address; qualified by cpu_req.
REQ-013 cpu_wdata  in  8  CPU write data; qualified by cpu_req.
REQ-014 cpu_busy  out  1  holding register occupied; cpu_req ignored while high.
REQ-015 cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
REQ-016 cpu_rdata  out  8  CPU read data.
REQ-017 mem_addr  out  AW  registered VRAM address.
REQ-018 mem_we  out  1  registered VRAM write enable.
REQ-019 mem_wdata  out  8  registered VRAM write data.
REQ-020 mem_rdata  in  8  VRAM read data, valid one cycle after mem_addr.

Function
REQ-021 At most one VRAM access is issued per cycle; a grant in cycle N drives mem_addr/mem_we/mem_wdata in cycle N+1.
REQ-022 Read data is captured from mem_rdata in cycle N+2 and presented with the owner's rvalid pulse in cycle N+3; fully pipelined, back-to-back grants every cycle.
REQ-023 The owner/read tag for each issued access travels in a 3-stage pipeline; writes produce no rvalid.
REQ-024 CPU side state machine: IDLE (holding register empty) and PEND (holding register full).
REQ-025 IDLE: cpu_req=1 captures cpu_we/cpu_addr/cpu_wdata, next state PEND, cpu_busy high from next cycle.
REQ-026 PEND: cpu_req is ignored; on CPU grant next state IDLE, cpu_busy low from the cycle after the grant.
REQ-027 Earliest CPU grant is the cycle after capture; no cycle-0 bypass.
REQ-028 Arbitration: display has priority; a pending CPU access is granted in any cycle disp_req=0.
REQ-029 disp_gnt = disp_req AND NOT (CPU forced grant this cycle).
REQ-030 When neither requester is granted, mem_we shall be 0 in the following cycle; mem_addr holds its last value.
REQ-031 Wait counter (8 bits) increments each PEND cycle without CPU grant, saturates at MAXWAIT, clears on CPU grant.

Reset
REQ-032 On reset: state IDLE, holding register cleared, wait counter 0, tag pipeline cleared, mem_addr 0, mem_we 0, mem_wdata 0, disp_rvalid 0, cpu_rvalid 0, disp_rdata 0, cpu_rdata 0, cpu_busy 0.
REQ-033 Reset mid-operation discards all in-flight accesses; no rvalid pulse in any cycle after reset is sampled high.
REQ-034 cpu_req coincident with reset is dropped.

Configuration
REQ-035 Macro VRAM_ARB_STARVE_EN defined: when the wait counter equals MAXWAIT the CPU is granted that cycle regardless of disp_req, and disp_gnt is 0.
REQ-036 Macro undefined: strict display priority, no forced grant, wait counter not implemented; CPU may wait indefinitely.

Verification
REQ-037 Idle bus, CPU read addr 0x0123 (mem holds 0x5A) at cycle 10 -> grant 11, mem_addr=0x0123 cycle 12, cpu_rvalid with 0x5A cycle 14, cpu_busy high 11..11 only.
REQ-038 disp_req held high 20 cycles, addresses 0..19 -> disp_rvalid every cycle 3 cycles after each grant, data matches memory, no gaps.
REQ-039 CPU write 0x3FFF<-0xA5 while disp_req high continuously, STARVE_EN, MAXWAIT=8 -> disp_gnt low exactly one cycle 9 cycles after capture, mem_we=1 addr 0x3FFF next cycle, no cpu_rvalid.
REQ-040 Same as REQ-039 without STARVE_EN -> no CPU grant while disp_req high; write issued first cycle disp_req drops.
REQ-041 Second cpu_req while cpu_busy=1 -> ignored, only first access reaches memory.
REQ-042 Reset asserted one cycle after a display grant -> no disp_rvalid afterwards, all outputs at REQ-032 values.
